// File: rtl/high_priority_status_tx_if.sv
// ---------------------------------------------------------------------------
// high_priority_status_tx_if
//   Handshake and payload bundle between the high-priority status packet
//   generator and the UDP transmitter.
//
//   udp_tx_request  generator -> tx : asks for a transmit slot
//   udp_tx_enable   tx -> generator : grant, one cycle or longer
//   udp_tx_data     generator -> tx : payload byte
//   udp_tx_valid    generator -> tx : udp_tx_data valid this cycle
//   udp_tx_last     generator -> tx : final payload byte
//   udp_tx_length   generator -> tx : payload length in bytes (constant)
//   udp_tx_port     generator -> tx : UDP source port (constant)
//
//   master = packet generator, slave = UDP transmitter.
// ---------------------------------------------------------------------------
interface high_priority_status_tx_if;
    logic        udp_tx_request;
    logic        udp_tx_enable;
    logic [7:0]  udp_tx_data;
    logic        udp_tx_valid;
    logic        udp_tx_last;
    logic [10:0] udp_tx_length;
    logic [15:0] udp_tx_port;

    modport master (
        output udp_tx_request,
        output udp_tx_data,
        output udp_tx_valid,
        output udp_tx_last,
        output udp_tx_length,
        output udp_tx_port,
        input  udp_tx_enable
    );

    modport slave (
        input  udp_tx_request,
        input  udp_tx_data,
        input  udp_tx_valid,
        input  udp_tx_last,
        input  udp_tx_length,
        input  udp_tx_port,
        output udp_tx_enable
    );
endinterface

// File: rtl/high_priority_status_tx.sv
// ---------------------------------------------------------------------------
// high_priority_status_tx
//   Builds the fixed-length high-priority status packet (sequence number,
//   key/PTT state, sticky ADC overload, power/voltage readings, user ADCs and
//   user IO) and hands it to the UDP transmitter. A packet is issued every
//   INTERVAL clocks while run is high, and early whenever a key/PTT input
//   changes. At most one extra packet can be queued while one is in flight.
//
// Ports
//   clock, reset_n            sole clock, asynchronous active-low reset
//   run                       packets generated only while high
//   PTT_in, Dot_in, Dash_in   key/PTT status
//   ADC_overload[7:0]         per-ADC overload strobes (accumulated, sticky)
//   Exciter_power, FWD_power, REV_power, Supply_volts [15:0]
//   User_ADC0..User_ADC3 [15:0], User_IO[7:0]
//   udp                       handshake/payload bundle to the UDP transmitter
// ---------------------------------------------------------------------------
module high_priority_status_tx #(
    parameter logic [15:0] port     = 16'd1025,
    parameter int          INTERVAL = 1228800,
    parameter int          PKT_LEN  = 60
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        run,
    input  logic        PTT_in,
    input  logic        Dot_in,
    input  logic        Dash_in,
    input  logic [7:0]  ADC_overload,
    input  logic [15:0] Exciter_power,
    input  logic [15:0] FWD_power,
    input  logic [15:0] REV_power,
    input  logic [15:0] Supply_volts,
    input  logic [15:0] User_ADC0,
    input  logic [15:0] User_ADC1,
    input  logic [15:0] User_ADC2,
    input  logic [15:0] User_ADC3,
    input  logic [7:0]  User_IO,
    high_priority_status_tx_if.master udp
);

    localparam int CNT_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam int IDX_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_WRAP = CNT_W'(INTERVAL - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

    typedef enum logic [1:0] {IDLE, REQUEST, SEND} state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [31:0]      seq_reg;
    logic             pending_reg;
    logic             pending_next;
    logic             run_d_reg;
    logic [2:0]       key_d_reg;
    logic [7:0]       ovl_acc_reg;

    logic             request_reg;
    logic             valid_reg;
    logic             last_reg;
    logic [7:0]       data_reg;

    // Snapshot taken on the grant edge; the payload reads only these.
    logic [2:0]       snap_keys_reg;
    logic [7:0]       snap_ovl_reg;
    logic [15:0]      snap_exc_reg;
    logic [15:0]      snap_fwd_reg;
    logic [15:0]      snap_rev_reg;
    logic [15:0]      snap_sup_reg;
    logic [7:0]       snap_io_reg;
    logic [15:0]      snap_adc_reg [4];
    logic [15:0]      user_adc     [4];

    logic [2:0]       keys;
    logic             trigger;
    logic             key_change;
    logic             grant;
    logic [IDX_W-1:0] next_idx;
    logic [31:0]      sel_idx;
    logic [7:0]       next_byte;

    assign keys       = {Dash_in, Dot_in, PTT_in};
    assign trigger    = run && (cnt_reg == CNT_WRAP);
    assign key_change = run && (keys != key_d_reg);
    assign grant      = (state_reg == REQUEST) && run && udp.udp_tx_enable;

    assign user_adc[0] = User_ADC0;
    assign user_adc[1] = User_ADC1;
    assign user_adc[2] = User_ADC2;
    assign user_adc[3] = User_ADC3;

    assign udp.udp_tx_request = request_reg;
    assign udp.udp_tx_valid   = valid_reg;
    assign udp.udp_tx_last    = last_reg;
    assign udp.udp_tx_data    = data_reg;
    assign udp.udp_tx_length  = 11'(PKT_LEN);
    assign udp.udp_tx_port    = port;

    // Pending: a trigger that lands while a packet is already in progress, or
    // any key edge, queues one more packet. A new event on the grant cycle
    // wins over the clear so it is not lost. Dropping run discards the queue.
    always_comb begin
        pending_next = pending_reg;
        if (grant)
            pending_next = 1'b0;
        if (key_change || (trigger && (state_reg != IDLE)))
            pending_next = 1'b1;
        if (!run)
            pending_next = 1'b0;
    end

    // Byte to present on the next cycle. On the grant edge the index is 0,
    // which only needs the live sequence register; snapshot-based bytes are
    // not needed until the snapshot has been captured.
    always_comb begin
        next_idx  = (state_reg == SEND) ? (idx_reg + IDX_W'(1)) : '0;
        sel_idx   = 32'(next_idx);
        next_byte = 8'h00;
        case (sel_idx)
            0:       next_byte = seq_reg[31:24];
            1:       next_byte = seq_reg[23:16];
            2:       next_byte = seq_reg[15:8];
            3:       next_byte = seq_reg[7:0];
            4:       next_byte = {5'b0, snap_keys_reg};
            5:       next_byte = snap_ovl_reg;
            6:       next_byte = snap_exc_reg[15:8];
            7:       next_byte = snap_exc_reg[7:0];
            14:      next_byte = snap_fwd_reg[15:8];
            15:      next_byte = snap_fwd_reg[7:0];
            22:      next_byte = snap_rev_reg[15:8];
            23:      next_byte = snap_rev_reg[7:0];
            49:      next_byte = snap_sup_reg[15:8];
            50:      next_byte = snap_sup_reg[7:0];
            51:      next_byte = snap_adc_reg[3][15:8];
            52:      next_byte = snap_adc_reg[3][7:0];
            53:      next_byte = snap_adc_reg[2][15:8];
            54:      next_byte = snap_adc_reg[2][7:0];
            55:      next_byte = snap_adc_reg[1][15:8];
            56:      next_byte = snap_adc_reg[1][7:0];
            57:      next_byte = snap_adc_reg[0][15:8];
            58:      next_byte = snap_adc_reg[0][7:0];
            59:      next_byte = snap_io_reg;
            default: next_byte = 8'h00;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_adc_snap
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n)
                    snap_adc_reg[gi] <= '0;
                else if (grant)
                    snap_adc_reg[gi] <= user_adc[gi];
            end
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            idx_reg       <= '0;
            seq_reg       <= '0;
            pending_reg   <= 1'b0;
            run_d_reg     <= 1'b0;
            key_d_reg     <= '0;
            ovl_acc_reg   <= '0;
            request_reg   <= 1'b0;
            valid_reg     <= 1'b0;
            last_reg      <= 1'b0;
            data_reg      <= '0;
            snap_keys_reg <= '0;
            snap_ovl_reg  <= '0;
            snap_exc_reg  <= '0;
            snap_fwd_reg  <= '0;
            snap_rev_reg  <= '0;
            snap_sup_reg  <= '0;
            snap_io_reg   <= '0;
        end else begin
            run_d_reg   <= run;
            key_d_reg   <= keys;
            pending_reg <= pending_next;

            if (!run || trigger)
                cnt_reg <= '0;
            else
                cnt_reg <= cnt_reg + CNT_W'(1);

            // Strobes on the grant cycle go into both the snapshot and the
            // fresh accumulator, so none can fall between two packets.
            if (grant)
                ovl_acc_reg <= ADC_overload;
            else
                ovl_acc_reg <= ovl_acc_reg | ADC_overload;

            case (state_reg)
                IDLE: begin
                    if (run && (trigger || pending_reg)) begin
                        state_reg   <= REQUEST;
                        request_reg <= 1'b1;
                    end
                end
                REQUEST: begin
                    if (!run) begin
                        state_reg   <= IDLE;
                        request_reg <= 1'b0;
                    end else if (udp.udp_tx_enable) begin
                        state_reg     <= SEND;
                        request_reg   <= 1'b0;
                        idx_reg       <= '0;
                        valid_reg     <= 1'b1;
                        last_reg      <= (PKT_LEN == 1);
                        data_reg      <= next_byte;
                        snap_keys_reg <= keys;
                        snap_ovl_reg  <= ovl_acc_reg | ADC_overload;
                        snap_exc_reg  <= Exciter_power;
                        snap_fwd_reg  <= FWD_power;
                        snap_rev_reg  <= REV_power;
                        snap_sup_reg  <= Supply_volts;
                        snap_io_reg   <= User_IO;
                    end
                end
                SEND: begin
                    // run is deliberately ignored here: a started packet
                    // always runs to its last byte.
                    if (idx_reg == LAST_IDX) begin
                        state_reg <= IDLE;
                        idx_reg   <= '0;
                        valid_reg <= 1'b0;
                        last_reg  <= 1'b0;
                        data_reg  <= '0;
                        seq_reg   <= seq_reg + 32'd1;
                    end else begin
                        idx_reg  <= next_idx;
                        data_reg <= next_byte;
                        last_reg <= (next_idx == LAST_IDX);
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    request_reg <= 1'b0;
                    valid_reg   <= 1'b0;
                    last_reg    <= 1'b0;
                    data_reg    <= '0;
                end
            endcase

            // A new run session always starts numbering from zero.
            if (run && !run_d_reg)
                seq_reg <= '0;
        end
    end

endmodule

// File: tb/tb_high_priority_status_tx.sv
// ---------------------------------------------------------------------------
// tb_high_priority_status_tx
//   Directed bench for high_priority_status_tx with INTERVAL=100, PKT_LEN=60.
//   Acts as the UDP transmitter (grants 3 cycles after each request) and
//   captures every packet for comparison against hand-set expected fields.
// ---------------------------------------------------------------------------
module tb_high_priority_status_tx;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        run = 1'b0;
    logic        PTT_in = 1'b0;
    logic        Dot_in = 1'b0;
    logic        Dash_in = 1'b0;
    logic [7:0]  ADC_overload = 8'h00;
    logic [15:0] Exciter_power = 16'h0E0F;
    logic [15:0] FWD_power = 16'hABCD;
    logic [15:0] REV_power = 16'h2223;
    logic [15:0] Supply_volts = 16'h1234;
    logic [15:0] User_ADC0 = 16'h0A0B;
    logic [15:0] User_ADC1 = 16'h1A1B;
    logic [15:0] User_ADC2 = 16'h2A2B;
    logic [15:0] User_ADC3 = 16'h3A3B;
    logic [7:0]  User_IO = 8'h5A;

    high_priority_status_tx_if udp_if ();

    high_priority_status_tx #(
        .port    (16'd1025),
        .INTERVAL(100),
        .PKT_LEN (60)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .run          (run),
        .PTT_in       (PTT_in),
        .Dot_in       (Dot_in),
        .Dash_in      (Dash_in),
        .ADC_overload (ADC_overload),
        .Exciter_power(Exciter_power),
        .FWD_power    (FWD_power),
        .REV_power    (REV_power),
        .Supply_volts (Supply_volts),
        .User_ADC0    (User_ADC0),
        .User_ADC1    (User_ADC1),
        .User_ADC2    (User_ADC2),
        .User_ADC3    (User_ADC3),
        .User_IO      (User_IO),
        .udp          (udp_if.master)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic [7:0] pkt [60];

    // Expected snapshot contents of the packet being captured.
    logic [31:0] g_seq  = 32'd0;
    logic [2:0]  g_keys = 3'd0;
    logic [7:0]  g_ovl  = 8'h00;
    logic [15:0] g_exc  = 16'h0E0F;
    logic [15:0] g_fwd  = 16'hABCD;
    logic [15:0] g_rev  = 16'h2223;
    logic [15:0] g_sup  = 16'h1234;
    logic [15:0] g_a0   = 16'h0A0B;
    logic [15:0] g_a1   = 16'h1A1B;
    logic [15:0] g_a2   = 16'h2A2B;
    logic [15:0] g_a3   = 16'h3A3B;
    logic [7:0]  g_io   = 8'h5A;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int i);
        case (i)
            0:  return g_seq[31:24];
            1:  return g_seq[23:16];
            2:  return g_seq[15:8];
            3:  return g_seq[7:0];
            4:  return {5'b0, g_keys};
            5:  return g_ovl;
            6:  return g_exc[15:8];
            7:  return g_exc[7:0];
            14: return g_fwd[15:8];
            15: return g_fwd[7:0];
            22: return g_rev[15:8];
            23: return g_rev[7:0];
            49: return g_sup[15:8];
            50: return g_sup[7:0];
            51: return g_a3[15:8];
            52: return g_a3[7:0];
            53: return g_a2[15:8];
            54: return g_a2[7:0];
            55: return g_a1[15:8];
            56: return g_a1[7:0];
            57: return g_a0[15:8];
            58: return g_a0[7:0];
            59: return g_io;
            default: return 8'h00;
        endcase
    endfunction

    task automatic wait_req(input string tag, input int budget, output int waited);
        waited = 0;
        while (!udp_if.udp_tx_request && waited < budget) begin
            @(negedge clock);
            waited++;
        end
        check({tag, " request seen"}, {31'd0, udp_if.udp_tx_request}, 32'd1);
    endtask

    // act: 0 none, 1 change inputs, 2 toggle PTT twice, 3 reset, 4 drop run
    task automatic capture(input string tag, input int act, input int act_at, output bit aborted);
        int nvalid;
        int nlast;
        int last_at;
        aborted = 1'b0;
        nvalid  = 0;
        nlast   = 0;
        last_at = -1;
        repeat (3) @(negedge clock);
        check({tag, " request held"}, {31'd0, udp_if.udp_tx_request}, 32'd1);
        udp_if.udp_tx_enable = 1'b1;
        @(negedge clock);
        udp_if.udp_tx_enable = 1'b0;
        check({tag, " request dropped"}, {31'd0, udp_if.udp_tx_request}, 32'd0);
        for (int i = 0; i < 60; i++) begin
            if (i > 0) @(negedge clock);
            pkt[i] = udp_if.udp_tx_data;
            if (udp_if.udp_tx_valid) nvalid++;
            if (udp_if.udp_tx_last) begin
                nlast++;
                last_at = i;
            end
            if (act == 2 && (i == act_at || i == act_at + 1)) begin
                PTT_in = ~PTT_in;
            end else if (i == act_at) begin
                case (act)
                    1: begin
                        FWD_power    = 16'h5555;
                        User_IO      = 8'hC3;
                        Supply_volts = 16'h9876;
                    end
                    3: begin
                        reset_n = 1'b0;
                        #1;
                        check({tag, " reset valid"}, {31'd0, udp_if.udp_tx_valid}, 32'd0);
                        check({tag, " reset last"}, {31'd0, udp_if.udp_tx_last}, 32'd0);
                        check({tag, " reset data"}, {24'd0, udp_if.udp_tx_data}, 32'd0);
                        check({tag, " reset request"}, {31'd0, udp_if.udp_tx_request}, 32'd0);
                        check({tag, " reset length"}, {21'd0, udp_if.udp_tx_length}, 32'd60);
                        aborted = 1'b1;
                    end
                    4: run = 1'b0;
                    default: ;
                endcase
            end
            if (aborted) break;
        end
        if (!aborted) begin
            check({tag, " valid count"}, nvalid, 60);
            check({tag, " last count"}, nlast, 1);
            check({tag, " last index"}, last_at, 59);
            @(negedge clock);
            check({tag, " valid after"}, {31'd0, udp_if.udp_tx_valid}, 32'd0);
            check({tag, " data after"}, {24'd0, udp_if.udp_tx_data}, 32'd0);
            for (int i = 0; i < 60; i++)
                check($sformatf("%s byte%0d", tag, i), {24'd0, pkt[i]}, {24'd0, exp_byte(i)});
        end
        $display("packet %s seq=%0d aborted=%0d valid=%0d last_at=%0d", tag, g_seq, aborted, nvalid, last_at);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c0;
        int unsigned r;
        int unsigned c;
        int w;
        bit ab;
        bit seen;

        udp_if.udp_tx_enable = 1'b0;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst request", {31'd0, udp_if.udp_tx_request}, 32'd0);
        check("rst valid", {31'd0, udp_if.udp_tx_valid}, 32'd0);
        check("rst last", {31'd0, udp_if.udp_tx_last}, 32'd0);
        check("rst data", {24'd0, udp_if.udp_tx_data}, 32'd0);
        check("rst length", {21'd0, udp_if.udp_tx_length}, 32'd60);
        check("rst port", {16'd0, udp_if.udp_tx_port}, 32'd1025);
        reset_n = 1'b1;
        repeat (5) @(negedge clock);
        check("idle while run low", {31'd0, udp_if.udp_tx_request}, 32'd0);

        // Periodic packets 0..3
        run = 1'b1;
        c0 = cyc;
        wait_req("p0", 150, w);
        check("p0 interval", cyc - c0, 100);
        r = cyc;
        g_seq = 0;
        capture("p0", 0, 0, ab);
        check("p0 fwd hi", {24'd0, pkt[14]}, 32'hAB);
        check("p0 fwd lo", {24'd0, pkt[15]}, 32'hCD);
        check("p0 sup hi", {24'd0, pkt[49]}, 32'h12);
        check("p0 sup lo", {24'd0, pkt[50]}, 32'h34);
        check("p0 user io", {24'd0, pkt[59]}, 32'h5A);

        wait_req("p1", 150, w);
        check("p1 interval", cyc - r, 100);
        r = cyc;
        g_seq = 1;
        capture("p1", 1, 5, ab);
        check("p1 seq lsb", {24'd0, pkt[3]}, 32'h01);
        check("p1 fwd hi frozen", {24'd0, pkt[14]}, 32'hAB);
        check("p1 user io frozen", {24'd0, pkt[59]}, 32'h5A);
        g_fwd = 16'h5555;
        g_io  = 8'hC3;
        g_sup = 16'h9876;

        // One-cycle overload strobe between packets
        ADC_overload = 8'h04;
        @(negedge clock);
        ADC_overload = 8'h00;

        wait_req("p2", 150, w);
        check("p2 interval", cyc - r, 100);
        r = cyc;
        g_seq = 2;
        g_ovl = 8'h04;
        capture("p2", 0, 0, ab);
        check("p2 ovl", {24'd0, pkt[5]}, 32'h04);
        check("p2 fwd hi new", {24'd0, pkt[14]}, 32'h55);

        wait_req("p3", 150, w);
        check("p3 interval", cyc - r, 100);
        g_seq = 3;
        g_ovl = 8'h00;
        capture("p3", 0, 0, ab);
        check("p3 ovl cleared", {24'd0, pkt[5]}, 32'h00);

        // Key-triggered packet, toggle during send, run drop mid-packet
        run = 1'b0;
        repeat (5) @(negedge clock);
        check("no req run low", {31'd0, udp_if.udp_tx_request}, 32'd0);
        run = 1'b1;
        repeat (10) @(negedge clock);
        PTT_in = 1'b1;
        c = cyc;
        wait_req("k", 20, w);
        check("k ptt latency", cyc - c, 2);
        g_seq  = 0;
        g_keys = 3'b001;
        capture("k", 2, 10, ab);
        check("k byte4", {24'd0, pkt[4]}, 32'h01);

        wait_req("f", 10, w);
        check("f gap", w, 1);
        g_seq = 1;
        capture("f", 4, 10, ab);

        seen = 1'b0;
        for (int i = 0; i < 250; i++) begin
            @(negedge clock);
            seen |= udp_if.udp_tx_request;
        end
        check("no req after run drop", {31'd0, seen}, 32'd0);

        run = 1'b1;
        c = cyc;
        wait_req("g", 150, w);
        check("g interval", cyc - c, 100);
        g_seq = 0;
        capture("g", 0, 0, ab);
        check("g seq restart", {24'd0, pkt[3]}, 32'h00);

        // Reset mid-packet
        wait_req("h", 150, w);
        g_seq = 1;
        capture("h", 3, 30, ab);
        check("h aborted", {31'd0, ab}, 32'd1);
        repeat (3) @(negedge clock);
        check("h in reset valid", {31'd0, udp_if.udp_tx_valid}, 32'd0);
        reset_n = 1'b1;
        wait_req("r", 200, w);
        g_seq = 0;
        capture("r", 0, 0, ab);
        check("r seq after reset", {24'd0, pkt[3]}, 32'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
